// File: rtl/ps2_key_src_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_src_if
//  Description : Key byte stream from the PS/2 keyboard front end to the
//                text-mode video-memory writer.
//                  key_out   [7:0] ASCII code of the last accepted key
//                  p_valid         one-cycle strobe marking a new key_out
//                  frame_err       one-cycle strobe marking a dropped frame
//                master = keyboard front end (drives), slave = consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_key_src_if;
   logic [7:0] key_out;
   logic       p_valid;
   logic       frame_err;

   modport master (output key_out, p_valid, frame_err);
   modport slave  (input  key_out, p_valid, frame_err);
endinterface
`default_nettype wire

// File: rtl/ps2_key_src.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_src
//  Description : PS/2 keyboard front end. Deserialises device-to-host frames,
//                decodes scan-code set 2 make/break sequences, tracks Shift
//                and emits one ASCII byte per printable key press (plus
//                Enter, Space, Backspace) as a single-cycle strobe.
//  Ports       : clk       system clock, rising edge
//                reset     asynchronous, active-low reset
//                ps2_clk   raw PS/2 clock pin (asynchronous)
//                ps2_data  raw PS/2 data pin (asynchronous)
//                kbd       master side of ps2_key_src_if
//                          (key_out, p_valid, frame_err)
//  Parameters  : TIMEOUT_CYCLES  idle clk cycles tolerated between PS/2
//                                falling edges inside a frame
//  Build macro : PS2_TIMEOUT_EN  enables the in-frame timeout; when undefined
//                                a partial frame waits indefinitely and
//                                TIMEOUT_CYCLES has no effect
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_src #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ps2_clk,
   input  logic          ps2_data,
   ps2_key_src_if.master kbd
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Pin synchronisers. Bit 0 is the newest sample. Reset to the idle-high
   // bus level so release of reset never looks like a falling edge.
   // ------------------------------------------------------------------------
   logic [2:0] r_clk_sync;
   logic [2:0] r_dat_sync;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_clk_sync <= 3'b111;
         r_dat_sync <= 3'b111;
      end else begin
         r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
         r_dat_sync <= {r_dat_sync[1:0], ps2_data};
      end
   end

   logic w_fall;
   logic w_bit;

   assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
   // Device data is stable for microseconds around the clock edge, so the
   // older data stage is as good as the newer one.
   assign w_bit  = r_dat_sync[2];

   // ------------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------------
   state_t     r_state, w_state_nxt;
   logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0] r_sr, w_sr_nxt;
   logic       r_par, w_par_nxt;
   logic       r_done, w_done_nxt;   // frame finished (good or dropped)
   logic       r_ok, w_ok_nxt;       // finished frame is good
   logic       w_timeout;

`ifdef PS2_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] r_to_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_to_cnt <= '0;
      end else if (w_fall || (r_state == IDLE)) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   // An edge arriving in the same cycle wins over the timeout.
   assign w_timeout = (r_state != IDLE) && !w_fall &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYCLES));
`else
   // Timeout never fires in this build.
   assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_bit_cnt <= 3'd0;
         r_sr      <= 8'h00;
         r_par     <= 1'b0;
         r_done    <= 1'b0;
         r_ok      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_sr      <= w_sr_nxt;
         r_par     <= w_par_nxt;
         r_done    <= w_done_nxt;
         r_ok      <= w_ok_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_sr_nxt      = r_sr;
      w_par_nxt     = r_par;
      w_done_nxt    = 1'b0;
      w_ok_nxt      = 1'b0;
      if (w_timeout) begin
         // Abort: the partial byte is simply overwritten by the next frame.
         w_state_nxt = IDLE;
         w_done_nxt  = 1'b1;
      end else if (w_fall) begin
         case (r_state)
            IDLE: begin
               if (!w_bit) begin
                  w_state_nxt   = DATA;
                  w_bit_cnt_nxt = 3'd0;
               end
            end
            DATA: begin
               w_sr_nxt      = {w_bit, r_sr[7:1]};   // LSB arrives first
               w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  w_state_nxt = PARITY;
               end
            end
            PARITY: begin
               w_par_nxt   = w_bit;
               w_state_nxt = STOP;
            end
            STOP: begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
               w_ok_nxt    = w_bit & (^{r_sr, r_par});
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Scan-code set 2 to ASCII lookup. Zero means "not mapped".
   // r_sr holds the finished byte until the next frame's first data bit,
   // which is far later than the decode cycle.
   // ------------------------------------------------------------------------
   logic [7:0] w_ascii;
   logic       w_hit;
   logic       w_letter;
   logic       w_is_shift;

   always_comb begin
      w_ascii = 8'h00;
      case (r_sr)
         8'h1C: w_ascii = "a";   8'h32: w_ascii = "b";   8'h21: w_ascii = "c";
         8'h23: w_ascii = "d";   8'h24: w_ascii = "e";   8'h2B: w_ascii = "f";
         8'h34: w_ascii = "g";   8'h33: w_ascii = "h";   8'h43: w_ascii = "i";
         8'h3B: w_ascii = "j";   8'h42: w_ascii = "k";   8'h4B: w_ascii = "l";
         8'h3A: w_ascii = "m";   8'h31: w_ascii = "n";   8'h44: w_ascii = "o";
         8'h4D: w_ascii = "p";   8'h15: w_ascii = "q";   8'h2D: w_ascii = "r";
         8'h1B: w_ascii = "s";   8'h2C: w_ascii = "t";   8'h3C: w_ascii = "u";
         8'h2A: w_ascii = "v";   8'h1D: w_ascii = "w";   8'h22: w_ascii = "x";
         8'h35: w_ascii = "y";   8'h1A: w_ascii = "z";
         8'h45: w_ascii = "0";   8'h16: w_ascii = "1";   8'h1E: w_ascii = "2";
         8'h26: w_ascii = "3";   8'h25: w_ascii = "4";   8'h2E: w_ascii = "5";
         8'h36: w_ascii = "6";   8'h3D: w_ascii = "7";   8'h3E: w_ascii = "8";
         8'h46: w_ascii = "9";
         8'h29: w_ascii = 8'h20;   // Space
         8'h5A: w_ascii = 8'h0A;   // Enter
         8'h66: w_ascii = 8'h08;   // Backspace
         default: w_ascii = 8'h00;
      endcase
   end

   assign w_hit      = (w_ascii != 8'h00);
   assign w_letter   = (w_ascii >= 8'h61) && (w_ascii <= 8'h7A);
   assign w_is_shift = (r_sr == 8'h12) || (r_sr == 8'h59);

   // ------------------------------------------------------------------------
   // Make/break decoder and output registers
   // ------------------------------------------------------------------------
   logic       r_brk;
   logic       r_ext;
   logic       r_shift_on;
   logic [7:0] r_key_out;
   logic       r_p_valid;
   logic       r_frame_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_brk       <= 1'b0;
         r_ext       <= 1'b0;
         r_shift_on  <= 1'b0;
         r_key_out   <= 8'h00;
         r_p_valid   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_p_valid   <= 1'b0;
         r_frame_err <= 1'b0;
         if (r_done && !r_ok) begin
            // Dropped frame (bad parity/stop or timeout): flags are kept.
            r_frame_err <= 1'b1;
         end else if (r_done) begin
            if (r_sr == 8'hF0) begin
               r_brk <= 1'b1;
            end else if (r_sr == 8'hE0) begin
               r_ext <= 1'b1;
            end else if (r_brk) begin
               // Release; only the plain (non-extended) shift codes matter.
               if (w_is_shift && !r_ext) begin
                  r_shift_on <= 1'b0;
               end
               r_brk <= 1'b0;
               r_ext <= 1'b0;
            end else if (r_ext) begin
               r_ext <= 1'b0;
            end else if (w_is_shift) begin
               r_shift_on <= 1'b1;
            end else if (w_hit) begin
               r_key_out <= (w_letter && r_shift_on) ? (w_ascii - 8'h20) : w_ascii;
               r_p_valid <= 1'b1;
            end
         end
      end
   end

   assign kbd.key_out   = r_key_out;
   assign kbd.p_valid   = r_p_valid;
   assign kbd.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_src.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_src
//  Description : Self-checking bench for ps2_key_src. Drives PS/2 frames on
//                the pins, predicts the key/error stream with a reference
//                decoder into a queue and compares each DUT strobe against
//                the head of the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_src;

   localparam int HALF = 20;   // clk cycles per PS/2 clock phase

   logic clk      = 1'b0;
   logic reset    = 1'b0;
   logic ps2_clk  = 1'b1;
   logic ps2_data = 1'b1;

   always #5 clk = ~clk;

   ps2_key_src_if kbd_if ();

   ps2_key_src #(.TIMEOUT_CYCLES(100)) dut (
      .clk      (clk),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .kbd      (kbd_if)
   );

   int         n_tests   = 0;
   int         n_fail    = 0;
   int         cyc       = 0;
   int         stop_cyc  = 0;
   bit         chk_lat   = 1'b1;
   logic [8:0] exp_q [$];         // {err, key}

   logic [7:0] tbl    [256];
   bit         is_let [256];
   bit         m_brk, m_ext, m_sh;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Strobe monitor / scoreboard
   always @(posedge clk) begin : mon
      logic [8:0] e;
      #1;
      if (kbd_if.p_valid || kbd_if.frame_err) begin
         check("exclusive", 32'(kbd_if.p_valid & kbd_if.frame_err), 32'd0);
         check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e[8]) begin
               check("frame_err", 32'(kbd_if.frame_err), 32'd1);
            end else begin
               check("p_valid", 32'(kbd_if.p_valid), 32'd1);
               check("key_out", 32'(kbd_if.key_out), 32'(e[7:0]));
            end
            if (chk_lat) check("latency", 32'(cyc - stop_cyc), 32'd3);
         end
      end
   end

   // Reference decoder: predicts strobes for one good byte.
   task automatic model(input logic [7:0] b);
      if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE0) m_ext = 1'b1;
      else if (m_brk) begin
         if ((b == 8'h12 || b == 8'h59) && !m_ext) m_sh = 1'b0;
         m_brk = 1'b0;
         m_ext = 1'b0;
      end
      else if (m_ext) m_ext = 1'b0;
      else if (b == 8'h12 || b == 8'h59) m_sh = 1'b1;
      else if (tbl[b] != 8'h00)
         exp_q.push_back({1'b0, (is_let[b] && m_sh) ? (tbl[b] - 8'h20) : tbl[b]});
   endtask

   task automatic ps2_bit(input logic b);
      @(negedge clk);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      @(posedge clk);
      #1 stop_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic ps2_frame(input logic [7:0] b, input logic par_flip, input logic stop_b);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ par_flip);
      ps2_bit(stop_b);
      repeat (HALF) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      model(b);
      ps2_frame(b, 1'b0, 1'b1);
   endtask

   task automatic send_bad(input logic [7:0] b, input logic par_flip, input logic stop_b);
      exp_q.push_back(9'h100);
      ps2_frame(b, par_flip, stop_b);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin : stim
      string      letters;
      logic [7:0] let_code [26];
      logic [7:0] dig_code [10];

      letters  = "abcdefghijklmnopqrstuvwxyz";
      let_code = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
      dig_code = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
      for (int i = 0; i < 256; i++) begin
         tbl[i]    = 8'h00;
         is_let[i] = 1'b0;
      end
      for (int i = 0; i < 26; i++) begin
         tbl[let_code[i]]    = letters[i];
         is_let[let_code[i]] = 1'b1;
      end
      for (int i = 0; i < 10; i++) tbl[dig_code[i]] = 8'h30 + i[7:0];
      tbl[8'h29] = 8'h20;
      tbl[8'h5A] = 8'h0A;
      tbl[8'h66] = 8'h08;
      m_brk = 1'b0; m_ext = 1'b0; m_sh = 1'b0;

      // Reset state
      repeat (5) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_key_out",   32'(kbd_if.key_out),   32'h00);
      check("rst_p_valid",   32'(kbd_if.p_valid),   32'd0);
      check("rst_frame_err", 32'(kbd_if.frame_err), 32'd0);

      // Single key, then its break code leaves key_out untouched
      send(8'h1C);
      check("a_drained", 32'(exp_q.size()), 32'd0);
      send(8'hF0); send(8'h1C);
      check("break_hold", 32'(kbd_if.key_out), 32'h61);

      // Shift make/break around a letter
      send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
      send(8'hF0); send(8'h12); send(8'h1C);
      check("shift_drained", 32'(exp_q.size()), 32'd0);

      // Enter, Space, Backspace, digit
      send(8'h5A); send(8'h29); send(8'h66); send(8'h16);
      check("special_drained", 32'(exp_q.size()), 32'd0);

      // Bad parity and bad stop bit are dropped
      send_bad(8'h1C, 1'b1, 1'b1);
      send_bad(8'h1C, 1'b0, 1'b0);
      check("bad_hold", 32'(kbd_if.key_out), 32'h31);
      check("bad_drained", 32'(exp_q.size()), 32'd0);

      // Extended keys are ignored, including their breaks
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      send(8'h1B);
      check("ext_drained", 32'(exp_q.size()), 32'd0);

`ifdef PS2_TIMEOUT_EN
      // Partial frame aborted by timeout; Shift survives the abort
      send(8'h12);
      chk_lat = 1'b0;
      exp_q.push_back(9'h100);
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
      repeat (150) @(negedge clk);
      chk_lat = 1'b1;
      check("timeout_drained", 32'(exp_q.size()), 32'd0);
      send(8'h29);
      send(8'h1C);
      send(8'hF0); send(8'h12);
      check("after_to_drained", 32'(exp_q.size()), 32'd0);
`endif

      // Reset mid-frame with Shift held: outputs and flags clear at once
      send(8'h12);
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_key_out",   32'(kbd_if.key_out),   32'h00);
      check("midrst_p_valid",   32'(kbd_if.p_valid),   32'd0);
      check("midrst_frame_err", 32'(kbd_if.frame_err), 32'd0);
      m_brk = 1'b0; m_ext = 1'b0; m_sh = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      send(8'h1C);
      send(8'h46);

      repeat (50) @(negedge clk);
      check("final_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
